// File: rtl/pipeline_stage3.sv
// Execute-side consumer of the stage-2 control word.
// Decodes the packed control fields into registered one-hot bus enables,
// index-register increment strobes and an address-source select, and owns
// the PC/RA flip flag, the bus-yield handshake and the break/halt state.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   controls_in[15:0] [3:0] assert sel, [7:4] load sel, [9:8] inc sel,
//                     [12:10] addr sel, [13] bus req, [14] pcra flip, [15] break
//   instruction_in    instruction travelling with controls_in
//   bus_grant         level grant from the external bus master
//   resume            single-cycle pulse releasing HALT
//   assert_en/load_en one-hot main-bus enables
//   inc_sp/si/di      index-register increment strobes
//   addr_sel          address-source select
//   instruction_out   instruction aligned with the enables
//   pcra_flag         PC/RA swap state
//   bus_req           request to the external master
//   fetch_suppress    stalls stage-2 fetch
//   halted            high while halted
//   bus_timeout       sticky grant-timeout flag
module pipeline_stage3 #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] controls_in,
    input  logic [7:0]  instruction_in,
    input  logic        bus_grant,
    input  logic        resume,
    output logic [15:0] assert_en,
    output logic [15:0] load_en,
    output logic        inc_sp,
    output logic        inc_si,
    output logic        inc_di,
    output logic [2:0]  addr_sel,
    output logic [7:0]  instruction_out,
    output logic        pcra_flag,
    output logic        bus_req,
    output logic        fetch_suppress,
    output logic        halted,
    output logic        bus_timeout
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned EN_W  = 16;

    typedef struct packed {
        logic       brk;
        logic       pcra;
        logic       bus;
        logic [2:0] addr;
        logic [1:0] inc;
        logic [3:0] ld;
        logic [3:0] as;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_BUSREQ,
        ST_BUSHELD,
        ST_HALT
    } state_t;

    ctrl_t              ctrl;
    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               pend, pend_d;
    logic               tmo_d, pcra_d;
    logic [EN_W-1:0]    assert_d, load_d;
    logic               inc_sp_d, inc_si_d, inc_di_d;
    logic [2:0]         addr_d;
    logic [7:0]         instr_d;

    assign ctrl = ctrl_t'(controls_in);

    // Select 0 means "nobody drives/loads", so it maps to an all-zero enable.
    function automatic logic [EN_W-1:0] onehot(input logic [3:0] sel);
        return (sel == 4'd0) ? '0 : (EN_W'(1) << sel);
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        pend_d   = pend;
        tmo_d    = bus_timeout;
        pcra_d   = pcra_flag;
        assert_d = '0;
        load_d   = '0;
        inc_sp_d = 1'b0;
        inc_si_d = 1'b0;
        inc_di_d = 1'b0;
        addr_d   = addr_sel;
        instr_d  = instruction_out;

        unique case (state)
            ST_RUN: begin
                assert_d = onehot(ctrl.as);
                load_d   = onehot(ctrl.ld);
                inc_sp_d = (ctrl.inc == 2'd1);
                inc_si_d = (ctrl.inc == 2'd2);
                inc_di_d = (ctrl.inc == 2'd3);
                addr_d   = ctrl.addr;
                instr_d  = instruction_in;
                if (ctrl.pcra) begin
                    pcra_d = ~pcra_flag;
                end
                // Bus yield takes precedence; a simultaneous break is deferred.
                if (ctrl.bus) begin
                    state_d = ST_BUSREQ;
                    cnt_d   = '0;
                    pend_d  = ctrl.brk;
                end else if (ctrl.brk) begin
                    state_d = ST_HALT;
                end
            end
            ST_BUSREQ: begin
                if (bus_grant) begin
                    state_d = ST_BUSHELD;
                    cnt_d   = '0;
                end else if ((cnt + CNT_W'(1)) == CNT_W'(BUS_TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = pend ? ST_HALT : ST_RUN;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_BUSHELD: begin
                if (!bus_grant) begin
                    state_d = pend ? ST_HALT : ST_RUN;
                    pend_d  = 1'b0;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // Sequencing state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            pend  <= pend_d;
        end
    end

    // Registered outputs; status flags follow the next state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            assert_en       <= '0;
            load_en         <= '0;
            inc_sp          <= 1'b0;
            inc_si          <= 1'b0;
            inc_di          <= 1'b0;
            addr_sel        <= '0;
            instruction_out <= '0;
            pcra_flag       <= 1'b0;
            bus_req         <= 1'b0;
            fetch_suppress  <= 1'b0;
            halted          <= 1'b0;
            bus_timeout     <= 1'b0;
        end else begin
            assert_en       <= assert_d;
            load_en         <= load_d;
            inc_sp          <= inc_sp_d;
            inc_si          <= inc_si_d;
            inc_di          <= inc_di_d;
            addr_sel        <= addr_d;
            instruction_out <= instr_d;
            pcra_flag       <= pcra_d;
            bus_req         <= (state_d == ST_BUSREQ) || (state_d == ST_BUSHELD);
            fetch_suppress  <= (state_d != ST_RUN);
            halted          <= (state_d == ST_HALT);
            bus_timeout     <= tmo_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stage3.sv
// Self-checking bench for pipeline_stage3: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model.
module tb_pipeline_stage3;

    localparam int TO = 4;
    localparam int M_RUN = 0, M_WAIT = 1, M_HOLD = 2, M_HALT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] controls_in;
    logic [7:0]  instruction_in;
    logic        bus_grant;
    logic        resume;
    logic [15:0] assert_en, load_en;
    logic        inc_sp, inc_si, inc_di;
    logic [2:0]  addr_sel;
    logic [7:0]  instruction_out;
    logic        pcra_flag, bus_req, fetch_suppress, halted, bus_timeout;

    int checks = 0;
    int errors = 0;

    pipeline_stage3 #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .controls_in(controls_in),
        .instruction_in(instruction_in), .bus_grant(bus_grant), .resume(resume),
        .assert_en(assert_en), .load_en(load_en), .inc_sp(inc_sp),
        .inc_si(inc_si), .inc_di(inc_di), .addr_sel(addr_sel),
        .instruction_out(instruction_out), .pcra_flag(pcra_flag),
        .bus_req(bus_req), .fetch_suppress(fetch_suppress), .halted(halted),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          mode;
        int          waited;
        bit          pend;
        bit          pcra;
        bit          tmo;
        logic [15:0] a;
        logic [15:0] l;
        bit          sp, si, di;
        logic [2:0]  addr;
        logic [7:0]  instr;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.mode = M_RUN; r.waited = 0; r.pend = 0; r.pcra = 0; r.tmo = 0;
        r.a = '0; r.l = '0; r.sp = 0; r.si = 0; r.di = 0;
        r.addr = '0; r.instr = '0;
        return r;
    endfunction

    function automatic model_t model_step(model_t p, logic [15:0] c,
                                          logic [7:0] ins, bit g, bit r);
        model_t n = p;
        n.a = '0; n.l = '0; n.sp = 0; n.si = 0; n.di = 0;
        case (p.mode)
            M_RUN: begin
                n.a[c[3:0]] = (c[3:0] != 4'd0);
                n.l[c[7:4]] = (c[7:4] != 4'd0);
                n.sp = (c[9:8] == 2'b01);
                n.si = (c[9:8] == 2'b10);
                n.di = (c[9:8] == 2'b11);
                n.addr = c[12:10];
                n.instr = ins;
                n.pcra = p.pcra ^ c[14];
                if (c[13]) begin
                    n.mode = M_WAIT; n.waited = 0; n.pend = c[15];
                end else if (c[15]) begin
                    n.mode = M_HALT;
                end
            end
            M_WAIT: begin
                if (g) begin
                    n.mode = M_HOLD;
                end else begin
                    n.waited = p.waited + 1;
                    if (n.waited == TO) begin
                        n.tmo = 1;
                        n.mode = p.pend ? M_HALT : M_RUN;
                        n.pend = 0;
                    end
                end
            end
            M_HOLD: begin
                if (!g) begin
                    n.mode = p.pend ? M_HALT : M_RUN;
                    n.pend = 0;
                end
            end
            default: begin
                if (r) n.mode = M_RUN;
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m, controls_in, instruction_in, bus_grant, resume);
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("m_assert_en", assert_en, m.a);
            chk("m_load_en", load_en, m.l);
            chk("m_inc", {13'd0, inc_sp, inc_si, inc_di}, {13'd0, m.sp, m.si, m.di});
            chk("m_addr_sel", 16'(addr_sel), 16'(m.addr));
            chk("m_instruction_out", 16'(instruction_out), 16'(m.instr));
            chk("m_pcra_flag", 16'(pcra_flag), 16'(m.pcra));
            chk("m_bus_req", 16'(bus_req), 16'(m.mode == M_WAIT || m.mode == M_HOLD));
            chk("m_fetch_suppress", 16'(fetch_suppress), 16'(m.mode != M_RUN));
            chk("m_halted", 16'(halted), 16'(m.mode == M_HALT));
            chk("m_bus_timeout", 16'(bus_timeout), 16'(m.tmo));
        end
    end

    // Apply one cycle of inputs; returns #1 after the edge that samples them.
    task automatic cyc(input logic [15:0] c, input logic [7:0] ins,
                       input logic g, input logic r);
        controls_in = c; instruction_in = ins; bus_grant = g; resume = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_assert"}, assert_en, 16'h0000);
        chk({tag, "_load"}, load_en, 16'h0000);
        chk({tag, "_flags"}, 16'({inc_sp, inc_si, inc_di, pcra_flag, bus_req,
                                 fetch_suppress, halted, bus_timeout}), 16'h0000);
        chk({tag, "_addr_instr"}, {5'd0, addr_sel, instruction_out}, 16'h0000);
    endtask

    initial begin
        logic [15:0] c;
        logic        g;
        reset = 1'b1; controls_in = '0; instruction_in = '0; bus_grant = 0; resume = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // Basic decode.
        cyc(16'h0053, 8'hA7, 0, 0);
        chk("d_assert_0053", assert_en, 16'h0008);
        chk("d_load_0053", load_en, 16'h0020);
        chk("d_inc_0053", 16'({inc_sp, inc_si, inc_di}), 16'h0000);
        chk("d_instr_0053", 16'(instruction_out), 16'h00A7);
        chk("d_fs_0053", 16'(fetch_suppress), 16'h0000);
        cyc(16'h1553, 8'h3C, 0, 0);
        chk("d_inc_sp", 16'({inc_sp, inc_si, inc_di}), 16'h0004);
        chk("d_addr_sel", 16'(addr_sel), 16'h0005);
        cyc(16'h0000, 8'h00, 0, 0);
        chk("d_zero_en", assert_en | load_en, 16'h0000);

        // PC/RA flip back-to-back.
        cyc(16'h4000, 8'h00, 0, 0);
        chk("d_pcra_1", 16'(pcra_flag), 16'h0001);
        cyc(16'h4000, 8'h00, 0, 0);
        chk("d_pcra_0", 16'(pcra_flag), 16'h0000);

        // Bus yield with grant after 3 cycles, held 4 cycles.
        cyc(16'h2000, 8'h11, 0, 0);
        chk("d_busreq_req", 16'({bus_req, fetch_suppress}), 16'h0003);
        cyc(16'h1FFF, 8'h22, 0, 0);
        cyc(16'h1FFF, 8'h22, 0, 0);
        chk("d_busreq_en_forced", assert_en | load_en, 16'h0000);
        chk("d_busreq_instr_hold", 16'(instruction_out), 16'h0011);
        for (int i = 0; i < 4; i++) begin
            cyc(16'h1FFF, 8'h22, 1, 0);
            chk("d_busheld_req", 16'({bus_req, fetch_suppress}), 16'h0003);
        end
        cyc(16'h0000, 8'h00, 0, 0);
        chk("d_bus_release", 16'({bus_req, fetch_suppress}), 16'h0000);

        // Grant timeout.
        cyc(16'h2000, 8'h00, 0, 0);
        for (int i = 0; i < TO - 1; i++) begin
            cyc(16'h0000, 8'h00, 0, 0);
            chk("d_wait_no_tmo", 16'({bus_req, bus_timeout}), 16'h0002);
        end
        cyc(16'h0000, 8'h00, 0, 0);
        chk("d_timeout", 16'({bus_req, bus_timeout, fetch_suppress}), 16'h0002);
        cyc(16'h0000, 8'h00, 0, 0);
        chk("d_timeout_sticky", 16'(bus_timeout), 16'h0001);

        // Break; a resume alongside the break word is ignored.
        cyc(16'h8000, 8'h00, 0, 1);
        chk("d_halt", 16'({halted, fetch_suppress}), 16'h0003);
        cyc(16'h0000, 8'h00, 0, 0);
        cyc(16'h0000, 8'h00, 0, 0);
        chk("d_halt_stay", 16'(halted), 16'h0001);
        cyc(16'h0000, 8'h00, 0, 1);
        chk("d_resume", 16'({halted, fetch_suppress}), 16'h0000);

        // Bus yield plus break: released into HALT.
        cyc(16'hA000, 8'h00, 0, 0);
        chk("d_a000_req", 16'({bus_req, halted}), 16'h0002);
        cyc(16'h0000, 8'h00, 1, 0);
        cyc(16'h0000, 8'h00, 1, 0);
        cyc(16'h0000, 8'h00, 0, 0);
        chk("d_a000_halt", 16'({bus_req, halted}), 16'h0001);
        cyc(16'h0000, 8'h00, 0, 1);

        // Asynchronous reset while in BUSHELD.
        cyc(16'h6000, 8'h5A, 0, 0);
        cyc(16'h0000, 8'h00, 1, 0);
        chk("d_pre_reset_held", 16'(bus_req), 16'h0001);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        bus_grant = 0;

        // Randomized traffic against the model.
        g = 0;
        for (int i = 0; i < 3000; i++) begin
            c = 16'($urandom);
            if ($urandom_range(0, 5) != 0) c[13] = 1'b0;
            if ($urandom_range(0, 7) != 0) c[15] = 1'b0;
            if ($urandom_range(0, 3) == 0) g = ~g;
            cyc(c, 8'($urandom), g, ($urandom_range(0, 4) == 0));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
